fir_level_meter: RTL and testbench
==================================

Name: fir_level_meter

Overview:
- Consumer end of the FIR filter output interface: accepts the signed 48-bit filtered value and its one-cycle ready strobe.
- Converts each filtered value into a 16-bit band level with instant attack, peak hold and stepped decay.
- Drives an 8-LED thermometer bar for that frequency band.
- One instance sits behind each band filter in the light-music chain.

Parameters:
- SHIFT, 24: right shift applied to |in_val| before 16-bit saturation.
- HOLD, 32: number of samples the peak is held after an attack.
- DECAY_DIV, 16: once hold has expired, decay is applied every DECAY_DIV samples (≥2).
- DECAY_SH, 4: decay step = level >> DECAY_SH, minimum 1.
- LED_BASE, 8: threshold for leds[i] is 2^(LED_BASE+i); LED_BASE ≤ 8.

Ports:
- clk  input  1  single system clock.
- reset  input  1  synchronous, active-high reset.
- in_val  input  48 signed  filtered value from the FIR filter.
- in_ready  input  1  one-cycle strobe; in_val is valid in that cycle.
- level  output  16  current band level, unsigned.
- leds  output  8  thermometer bar derived from level.
- level_ready  output  1  one-cycle strobe; level and leds updated this cycle.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. While reset is high at a clk edge, all registers clear: level=0, leds=0, level_ready=0, internal peak=0, hold_cnt=0, dcnt=0, all pipeline valids=0.
- Reset mid-operation: in-flight samples are discarded and produce no level_ready. in_ready is ignored while reset is high.
- Pipeline: 3 stages, fully pipelined. in_ready is accepted every cycle, including back-to-back. in_ready high in cycle n gives level_ready high in cycle n+3, exactly one cycle per accepted sample.
- Stage 1, magnitude:
  - mag = |in_val|; in_val = -2^47 maps to 2^47-1.
  - sc = mag >> SHIFT.
  - s1 = (sc > 16'hFFFF) ? 16'hFFFF : sc[15:0].
  - s1_valid = in_ready.
- Stage 2, peak/hold/decay. Applies only when s1_valid:
  - Attack (s1 ≥ peak): peak <= s1, hold_cnt <= HOLD, dcnt <= 0.
  - Else if hold_cnt != 0: hold_cnt <= hold_cnt-1; peak unchanged.
  - Else if dcnt == DECAY_DIV-1: dcnt <= 0.
    - step = peak >> DECAY_SH; if step == 0 and peak != 0, step = 1.
    - peak <= max(peak-step, s1). No underflow is possible.
  - Else: dcnt <= dcnt+1; peak unchanged.
  - s2_valid = s1_valid.
- Stage 3, outputs. When s2_valid:
  - level <= peak.
  - leds[i] <= (peak ≥ 2^(LED_BASE+i)) for i = 0..7.
  - level_ready <= s2_valid every cycle.
  - level and leds hold their values between strobes.
- Arithmetic: magnitude uses 48-bit unsigned math. hold_cnt and dcnt widths come from clog2 of HOLD+1 and DECAY_DIV.

Test Plan:
1. Reset: assert reset for 3 clocks while pulsing in_ready with in_val=2^38 -> level=0, leds=0, no level_ready during or after reset.
2. Single attack: in_val=48'h0040_0000_0000 (2^38), in_ready in cycle n -> level_ready only in cycle n+3, level=16'h4000, leds=8'h7F.
3. Sign and saturation:
   - in_val=-2^38 -> level=16'h4000.
   - in_val=2^40 -> level=16'hFFFF, leds=8'hFF.
   - in_val=-2^47 -> level=16'hFFFF.
4. Hold then decay: after the 16'h4000 attack, send 48 zero samples.
   - level=16'h4000 on zero samples 1..47.
   - level=16'h3C00 on sample 48.
   - Next decay on sample 64: 16'h3840.
5. Minimum step: peak=16'h000A held and expired, zeros continue -> level decrements by 1 every 16 samples down to 0 and stays 0. A sample with s1 between step result and peak clamps peak to s1.
6. Back-to-back plus reset mid-stream: in_ready high 5 consecutive cycles with rising values -> 5 consecutive level_ready pulses tracking each value. Repeat with reset in the 3rd cycle -> no level_ready after reset; outputs return to 0.

Source files
------------

// File: rtl/fir_level_meter.sv
// Band level meter behind one FIR band filter: |x| scaling, instant attack, peak hold, stepped decay, 8-LED bar.
// Three-stage pipeline, one result strobe per accepted sample three cycles later; no backpressure.
module fir_level_meter #(
  parameter int SHIFT     = 24,
  parameter int HOLD      = 32,
  parameter int DECAY_DIV = 16,
  parameter int DECAY_SH  = 4,
  parameter int LED_BASE  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [47:0] in_val,
  input  logic               in_ready,
  output logic [15:0]        level,
  output logic [7:0]         leds,
  output logic               level_ready
);

  localparam int HW = $clog2(HOLD + 1);
  localparam int DW = $clog2(DECAY_DIV);
  localparam logic [47:0] MAG_MAX = 48'h7FFF_FFFF_FFFF;
  localparam logic [47:0] MOST_NEG = 48'h8000_0000_0000;

  logic [47:0]   raw, mag, sc;
  logic [15:0]   s1_d, s1_q;
  logic          s1_vld_d, s1_vld_q;
  logic [15:0]   peak_d, peak_q, step, dec;
  logic [HW-1:0] hold_cnt_d, hold_cnt_q;
  logic [DW-1:0] dcnt_d, dcnt_q;
  logic          s2_vld_d, s2_vld_q;
  logic [15:0]   level_d, level_q;
  logic [7:0]    leds_d, leds_q;
  logic          level_ready_d, level_ready_q;

  always_comb begin
    raw      = in_val;
    mag      = raw;
    if (raw[47]) begin
      // The most negative input has no positive twin; clamp it to the largest magnitude.
      mag = (raw == MOST_NEG) ? MAG_MAX : (~raw + 48'd1);
    end
    sc       = mag >> SHIFT;
    s1_d     = (sc > 48'h0000_0000_FFFF) ? 16'hFFFF : sc[15:0];
    s1_vld_d = in_ready;
  end

  always_comb begin
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    dcnt_d     = dcnt_q;
    s2_vld_d   = s1_vld_q;
    step       = peak_q >> DECAY_SH;
    if (step == 16'd0 && peak_q != 16'd0) begin
      step = 16'd1;
    end
    dec = peak_q - step;
    if (s1_vld_q) begin
      if (s1_q >= peak_q) begin
        peak_d     = s1_q;
        hold_cnt_d = HW'(HOLD);
        dcnt_d     = '0;
      end else if (hold_cnt_q != '0) begin
        hold_cnt_d = hold_cnt_q - HW'(1);
      end else if (dcnt_q == DW'(DECAY_DIV - 1)) begin
        dcnt_d = '0;
        peak_d = (dec > s1_q) ? dec : s1_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    level_d       = level_q;
    leds_d        = leds_q;
    level_ready_d = s2_vld_q;
    if (s2_vld_q) begin
      level_d = peak_q;
      for (int i = 0; i < 8; i++) begin
        leds_d[i] = ({16'd0, peak_q} >= (32'd1 << (LED_BASE + i)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q          <= '0;
      s1_vld_q      <= 1'b0;
      peak_q        <= '0;
      hold_cnt_q    <= '0;
      dcnt_q        <= '0;
      s2_vld_q      <= 1'b0;
      level_q       <= '0;
      leds_q        <= '0;
      level_ready_q <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s1_vld_q      <= s1_vld_d;
      peak_q        <= peak_d;
      hold_cnt_q    <= hold_cnt_d;
      dcnt_q        <= dcnt_d;
      s2_vld_q      <= s2_vld_d;
      level_q       <= level_d;
      leds_q        <= leds_d;
      level_ready_q <= level_ready_d;
    end
  end

  assign level       = level_q;
  assign leds        = leds_q;
  assign level_ready = level_ready_q;

endmodule

// File: tb/tb_fir_level_meter.sv
// Bench for fir_level_meter: vector table, hand-written hold/decay/reset sequences, and randomized traffic
// checked against a sample-count reference model of the meter.
module tb_fir_level_meter;

  localparam int SHIFT = 24, HOLD = 32, DECAY_DIV = 16, DECAY_SH = 4, LED_BASE = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [47:0] in_val = '0;
  logic               in_ready = 1'b0;
  logic [15:0]        level;
  logic [7:0]         leds;
  logic               level_ready;

  fir_level_meter #(.SHIFT(SHIFT), .HOLD(HOLD), .DECAY_DIV(DECAY_DIV),
                    .DECAY_SH(DECAY_SH), .LED_BASE(LED_BASE)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_ready(in_ready),
    .level(level), .leds(leds), .level_ready(level_ready)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int n_pulses = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: the peak plus the number of non-attack samples since the last attack.
  int model_peak = 0;
  int model_k = 0;

  function automatic int s1_of(input logic signed [47:0] v);
    longint a;
    a = longint'(v);
    if (a < 0) a = -a;
    if (a > 64'sh7FFF_FFFF_FFFF) a = 64'sh7FFF_FFFF_FFFF;
    a = a / (64'sd1 << SHIFT);
    return (a > 65535) ? 65535 : int'(a);
  endfunction

  function automatic logic [7:0] bar_of(input int p);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (p >= (1 << (LED_BASE + i)));
    return b;
  endfunction

  function automatic void model_step(input int s);
    int st, d;
    if (s >= model_peak) begin
      model_peak = s;
      model_k = 0;
    end else begin
      model_k++;
      if (model_k > HOLD && ((model_k - HOLD) % DECAY_DIV) == 0) begin
        st = model_peak / (1 << DECAY_SH);
        if (st == 0) st = 1;
        d = model_peak - st;
        model_peak = (d > s) ? d : s;
      end
    end
  endfunction

  typedef struct {
    int         cyc;
    logic [15:0] lvl;
    logic [7:0]  bar;
  } exp_t;
  exp_t expq[$];

  always @(negedge clk) begin
    if (level_ready) begin
      n_pulses++;
      if (expq.size() == 0) begin
        chk("unexpected_level_ready", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_level", level, e.lvl);
        chk("strobe_leds", leds, e.bar);
      end
    end
  end

  task automatic send(input logic signed [47:0] v);
    exp_t e;
    @(posedge clk); #1;
    in_val = v;
    in_ready = 1'b1;
    model_step(s1_of(v));
    e.cyc = cyc + 3;
    e.lvl = 16'(model_peak);
    e.bar = bar_of(model_peak);
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_ready = 1'b0;
    end
  endtask

  task automatic do_reset(input int n, input bit pulse);
    @(posedge clk); #1;
    reset = 1'b1;
    in_ready = pulse;
    in_val = 48'sh0040_0000_0000;
    // Samples still inside the pipeline when reset lands never come out.
    while (expq.size() > 0 && expq[$].cyc > cyc) void'(expq.pop_back());
    model_peak = 0;
    model_k = 0;
    repeat (n - 1) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    reset = 1'b0;
    in_ready = 1'b0;
  endtask

  task automatic sample_out(input string name, input logic [15:0] lvl, input logic [7:0] bar);
    @(negedge clk);
    chk({name, "_level"}, level, lvl);
    chk({name, "_leds"}, leds, bar);
  endtask

  task automatic zeros(input int n);
    repeat (n) send(48'sd0);
  endtask

  typedef struct {
    logic signed [47:0] v;
    logic [15:0]        lvl;
    logic [7:0]         bar;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int p0;
    logic [47:0] r;

    vecs[0] = '{48'sh0040_0000_0000, 16'h4000, 8'h7F};
    vecs[1] = '{-48'sh0040_0000_0000, 16'h4000, 8'h7F};
    vecs[2] = '{48'sh0100_0000_0000, 16'hFFFF, 8'hFF};
    vecs[3] = '{48'sh8000_0000_0000, 16'hFFFF, 8'hFF};
    vecs[4] = '{48'sh7FFF_FFFF_FFFF, 16'hFFFF, 8'hFF};
    vecs[5] = '{48'sh0000_0100_0000, 16'h0001, 8'h00};
    vecs[6] = '{-48'sh0000_0100_0000, 16'h0001, 8'h00};
    vecs[7] = '{48'sh0000_00FF_FFFF, 16'h0000, 8'h00};
    vecs[8] = '{48'sh0001_0000_0000, 16'h0100, 8'h01};
    vecs[9] = '{48'sh007F_FFFF_FFFF, 16'h7FFF, 8'h7F};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sample_out("reset_state", 16'h0000, 8'h00);
    chk("reset_state_ready", level_ready, 0);

    // Reset held three clocks with in_ready pulsing must produce nothing.
    do_reset(3, 1'b1);
    idle(5);
    sample_out("reset_pulsed", 16'h0000, 8'h00);
    chk("reset_pulsed_ready", level_ready, 0);
    chk("reset_pulsed_count", n_pulses, 0);

    for (int i = 0; i < 10; i++) begin
      do_reset(2, 1'b0);
      send(vecs[i].v);
      idle(4);
      sample_out($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].bar);
    end

    // Hold, first two decay steps, then a decay clamped by the incoming sample.
    do_reset(2, 1'b0);
    send(48'sh0040_0000_0000);
    zeros(47);
    idle(4);
    sample_out("hold_47", 16'h4000, 8'h7F);
    zeros(1);
    idle(4);
    sample_out("decay_48", 16'h3C00, 8'h3F);
    zeros(15);
    idle(4);
    sample_out("decay_63", 16'h3C00, 8'h3F);
    zeros(1);
    idle(4);
    sample_out("decay_64", 16'h3840, 8'h3F);
    zeros(15);
    send(48'sh0036_0000_0000);
    idle(4);
    sample_out("decay_clamp", 16'h3600, 8'h3F);

    // Minimum step of one once the shifted step underflows.
    do_reset(2, 1'b0);
    send(48'sh0000_0A00_0000);
    zeros(47);
    idle(4);
    sample_out("min_hold", 16'h000A, 8'h00);
    zeros(1);
    idle(4);
    sample_out("min_step1", 16'h0009, 8'h00);
    zeros(16);
    idle(4);
    sample_out("min_step2", 16'h0008, 8'h00);
    zeros(16 * 8);
    idle(4);
    sample_out("min_zero", 16'h0000, 8'h00);
    zeros(40);
    idle(4);
    sample_out("min_stay", 16'h0000, 8'h00);

    // Back-to-back rising samples, then reset landing in the third cycle of a burst.
    do_reset(2, 1'b0);
    p0 = n_pulses;
    for (int i = 1; i <= 5; i++) send(48'(i) << 32);
    idle(5);
    chk("b2b_count", n_pulses - p0, 5);
    sample_out("b2b_last", 16'h0500, 8'h07);
    p0 = n_pulses;
    send(48'sh0006_0000_0000);
    send(48'sh0007_0000_0000);
    do_reset(1, 1'b1);
    idle(6);
    chk("mid_reset_count", n_pulses - p0, 0);
    sample_out("mid_reset", 16'h0000, 8'h00);

    // Randomized traffic with gaps and occasional resets.
    do_reset(2, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 2), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else if ($urandom_range(0, 2) == 0) begin
        send(48'sd0);
      end else begin
        r = 48'({$urandom(), $urandom()}) >> $urandom_range(8, 40);
        if ($urandom_range(0, 1) == 1) r = ~r + 48'd1;
        send(r);
      end
    end
    idle(6);
    chk("queue_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
